// File: rtl/count_seq_ctrl.sv
// Triangle-sweep counter controller: counts lo->hi, holds at hi for a
// configurable dwell, counts back down to lo, then either stops or repeats.
module count_seq_ctrl #(
  parameter int WIDTH   = 4,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [DWELL_W-1:0] dwell,
  output logic [WIDTH-1:0]   counter,
  output logic               up_down,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    HOLD = 2'd2,
    DOWN = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic                 ud_q, ud_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic                 mode_q, mode_d;
  logic [DWELL_W-1:0]   dcnt_q, dcnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  // State, datapath and pulse registers; reset clears everything but direction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ud_q    <= 1'b1;
      lo_q    <= '0;
      hi_q    <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
      dcnt_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ud_q    <= ud_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      dcnt_q  <= dcnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: sweep sequencing works only from the latched config,
  // and the bounds comparisons keep the counter from ever wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ud_d    = ud_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    dcnt_d  = dcnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (lo < hi) begin
            lo_d    = lo;
            hi_d    = hi;
            dwell_d = dwell;
            mode_d  = mode;
            cnt_d   = lo;
            ud_d    = 1'b1;
            state_d = UP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      UP: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q < hi_q) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          dcnt_d  = dwell_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (dcnt_q != '0) begin
          dcnt_d = dcnt_q - 1'b1;
        end else begin
          ud_d    = 1'b0;
          state_d = DOWN;
        end
      end
      DOWN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q > lo_q) begin
          cnt_d = cnt_q - 1'b1;
        end else if (mode_q) begin
          ud_d    = 1'b1;
          state_d = UP;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs come straight from registers so nothing combinational leaks out.
  always_comb begin
    counter = cnt_q;
    up_down = ud_q;
    busy    = (state_q != IDLE);
    done    = done_q;
    err     = err_q;
    state   = state_q;
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: expected traces are built from the sweep rules
// (up run, hold run, down run) and compared cycle by cycle.
module tb_count_seq_ctrl;
  localparam int W  = 4;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mode = 1'b0;
  logic [W-1:0]  lo = '0;
  logic [W-1:0]  hi = '0;
  logic [DW-1:0] dwell = '0;
  logic [W-1:0]  counter;
  logic          up_down, busy, done, err;
  logic [1:0]    state;

  count_seq_ctrl #(.WIDTH(W), .DWELL_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .lo(lo), .hi(hi), .dwell(dwell),
    .counter(counter), .up_down(up_down), .busy(busy), .done(done),
    .err(err), .state(state)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] c;
    logic         ud;
    logic         busy;
    logic         done;
    logic         err;
    logic [1:0]   st;
  } obs_t;

  obs_t obs;
  assign obs = {counter, up_down, busy, done, err, state};

  obs_t         expQ[$];
  int           checkCount = 0;
  int           passCount  = 0;
  logic [W-1:0] modelCnt = '0;
  logic         modelUd  = 1'b1;

  function automatic obs_t mk(input int c, input bit ud, input int st,
                              input bit dn, input bit er);
    obs_t o;
    o.c    = W'(c);
    o.ud   = ud;
    o.busy = (st != 0);
    o.done = dn;
    o.err  = er;
    o.st   = 2'(st);
    return o;
  endfunction

  task automatic checkOutput(input string tag, input obs_t e);
    checkCount++;
    assert (obs === e) passCount++;
    else $error("[TB] FAIL %s: got c=%0d ud=%0b busy=%0b done=%0b err=%0b st=%0d, want c=%0d ud=%0b busy=%0b done=%0b err=%0b st=%0d",
                tag, obs.c, obs.ud, obs.busy, obs.done, obs.err, obs.st,
                e.c, e.ud, e.busy, e.done, e.err, e.st);
    modelCnt = e.c;
    modelUd  = e.ud;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One period: up run lo..hi, dwell+1 hold cycles at hi, down run hi..lo.
  task automatic buildTrace(input int l, input int h, input int d,
                            input int m, input int periods);
    expQ.delete();
    for (int p = 0; p < periods; p++) begin
      for (int v = l; v <= h; v++) expQ.push_back(mk(v, 1'b1, 1, 1'b0, 1'b0));
      for (int k = 0; k <= d; k++) expQ.push_back(mk(h, 1'b1, 2, 1'b0, 1'b0));
      for (int v = h; v >= l; v--) expQ.push_back(mk(v, 1'b0, 3, 1'b0, 1'b0));
    end
    if (m == 0) expQ.push_back(mk(l, 1'b0, 0, 1'b1, 1'b0));
  endtask

  // Launch a sweep and follow its trace; optionally scramble inputs while busy,
  // abort with stop after index stopAt, or drop reset after index resetAt.
  task automatic applyStimulus(input string name, input int l, input int h,
                               input int d, input int m, input int periods,
                               input bit scramble, input int stopAt,
                               input int resetAt, input bit bothHigh);
    buildTrace(l, h, d, m, periods);
    lo = W'(l); hi = W'(h); dwell = DW'(d); mode = m[0];
    start = 1'b1;
    stop  = bothHigh;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < expQ.size(); i++) begin
      if (i > 0) tick();
      checkOutput($sformatf("%s[%0d]", name, i), expQ[i]);
      if (i == resetAt) begin
        #2;
        rst = 1'b0;
        #1;
        checkOutput({name, "_async_rst"}, mk(0, 1'b1, 0, 1'b0, 1'b0));
        return;
      end
      if (i == stopAt) begin
        stop  = 1'b1;
        start = 1'b1;
        tick();
        stop  = 1'b0;
        start = 1'b0;
        checkOutput({name, "_stop"}, mk(expQ[i].c, expQ[i].ud, 0, 1'b0, 1'b0));
        return;
      end
      if (scramble && i < expQ.size() - 1) begin
        lo    = W'($urandom);
        hi    = W'($urandom);
        dwell = DW'($urandom);
        mode  = 1'($urandom);
        start = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int l, h, d, m, per, sAt;

    // Reset state, then idle after release.
    rst = 1'b0;
    tick();
    checkOutput("reset", mk(0, 1'b1, 0, 1'b0, 1'b0));
    #3 rst = 1'b1;
    tick();
    checkOutput("idle_after_reset", mk(0, 1'b1, 0, 1'b0, 1'b0));
    tick();
    checkOutput("idle_stays", mk(0, 1'b1, 0, 1'b0, 1'b0));

    // Directed single sweep lo=2 hi=5 dwell=1.
    applyStimulus("single", 2, 5, 1, 0, 1, 1'b0, -1, -1, 1'b0);
    tick();
    checkOutput("single_done_clears", mk(2, 1'b0, 0, 1'b0, 1'b0));

    // Bad config: lo == hi, then lo > hi.
    lo = 4'd7; hi = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("err_equal", mk(modelCnt, modelUd, 0, 1'b0, 1'b1));
    tick();
    checkOutput("err_clears", mk(modelCnt, modelUd, 0, 1'b0, 1'b0));
    lo = 4'd12; hi = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("err_lo_gt_hi", mk(modelCnt, modelUd, 0, 1'b0, 1'b1));
    tick();
    checkOutput("err_lo_gt_hi_clears", mk(modelCnt, modelUd, 0, 1'b0, 1'b0));

    // Full-range continuous sweeps, started with start and stop both high.
    applyStimulus("cont", 0, 15, 0, 1, 3, 1'b0, 2 * 33 + 5, -1, 1'b1);
    tick();
    checkOutput("cont_idle", mk(modelCnt, modelUd, 0, 1'b0, 1'b0));

    // Abort in DOWN at counter=3 with scrambled inputs and start while busy.
    applyStimulus("abort", 1, 6, 2, 0, 1, 1'b1, 6 + 3 + 3, -1, 1'b0);
    tick();
    checkOutput("abort_idle", mk(3, 1'b0, 0, 1'b0, 1'b0));

    // Randomized sweeps against the trace model, inputs scrambled while busy.
    for (int n = 0; n < 8; n++) begin
      l   = int'($urandom_range(0, 12));
      h   = int'($urandom_range(l + 1, 15));
      d   = int'($urandom_range(0, 3));
      m   = int'($urandom_range(0, 1));
      per = (m == 1) ? 2 : 1;
      sAt = (m == 1) ? int'($urandom_range(0, per * (2 * (h - l + 1) + d + 1) - 1)) : -1;
      applyStimulus($sformatf("rand%0d", n), l, h, d, m, per, 1'b1, sAt, -1, 1'b0);
      tick();
      checkOutput($sformatf("rand%0d_idle", n), mk(modelCnt, modelUd, 0, 1'b0, 1'b0));
    end

    // Asynchronous reset in the middle of HOLD.
    applyStimulus("rst", 3, 8, 5, 0, 1, 1'b0, -1, (8 - 3 + 1) + 1, 1'b0);
    tick();
    checkOutput("rst_held", mk(0, 1'b1, 0, 1'b0, 1'b0));
    #3 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput($sformatf("rst_release[%0d]", k), mk(0, 1'b1, 0, 1'b0, 1'b0));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
